pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter / fetch sequencer feeding the 5-bit instruction ROM of the 16-bit core.
//  Holds PC and presents it to instr_memory; instr_memory returns the word combinationally.
//  Partially decodes the fetched word for control flow: bne, beq, j; all else falls through.
//  Adds a start/run/halt FSM, a stall hook and a retired-instruction counter.
// PARAMETERS
//  PC_W      5   PC width; ROM depth = 2**PC_W
//  RESET_PC  0   PC value loaded by reset
//  CNT_W     16  width of retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      pulse: leave IDLE and begin fetching at current PC
//  stall        in   1      hold PC; nothing retires this cycle
//  instruction  in   16     word from instr_memory at address pc (same cycle)
//  regs_equal   in   1      datapath compare: R[instr[11:8]] == R[instr[7:4]]
//  pc           out  PC_W   current fetch address to instr_memory
//  running      out  1      FSM in RUN
//  halted       out  1      FSM in HALT
//  retired      out  CNT_W  count of instructions retired since reset
// BEHAVIOUR
//  Format: op=instr[15:12], offset=instr[3:0] signed; jump target=instr[PC_W-1:0].
//  Opcodes: BEQ=4'b1100, BNE=4'b1110, J=4'b1111; any other op -> sequential.
//  Reset: pc=RESET_PC, state=IDLE, running=0, halted=0, retired=0; rst wins over all inputs.
//  FSM states:
//   IDLE: pc frozen, no retire; start=1 -> RUN next cycle; start ignored in RUN/HALT.
//   RUN : each non-stalled cycle retires the word at pc and updates pc by priority:
//         J -> target; BNE & !regs_equal -> pc+1+sext(offset);
//         BEQ & regs_equal -> pc+1+sext(offset); else pc+1.
//         J with target==pc (self-jump) -> HALT; pc unchanged; this jump still retires.
//   HALT: pc, retired frozen; only rst exits.
//  stall=1 in RUN: pc, retired, state all hold; instruction ignored that cycle.
//  Arithmetic: all PC math modulo 2**PC_W; 31+1 -> 0; 1+1+(-3) -> 31.
//  Branch not taken == pc+1. Offset sign-extended from 4 bits to PC_W before add.
//  Latency: new pc visible on the clock edge after the deciding cycle (single-cycle core).
//  retired saturates at all-ones; no wrap.
//  running/halted are registered state decodes; never both 1.
//  Reset mid-RUN/HALT: next cycle is IDLE with pc=RESET_PC, retired=0.
// STRUCTURE
//  Shared package (cpu_pkg): opcode constants BEQ/BNE/J, field index constants,
//   FSM state encoding (IDLE/RUN/HALT), PC_W default.
//  One sub-module natural: next_pc_calc (combinational next-PC mux + sign-extend adder);
//   FSM, pc register, and counter stay in pc_fetch_unit.
// TESTING
//  Reset, start pulse, 4 ALU words at 0..3 -> pc 0,1,2,3,4 on consecutive edges; retired=4.
//  pc=7, word 16'hE30D (bne), regs_equal=0 -> pc=5; regs_equal=1 -> pc=8.
//  pc=31, ALU word -> pc wraps to 0; pc=1, beq off=-3 taken -> pc=31.
//  pc=11, word 16'hF01F -> pc=31; at 31 word 16'hF01F -> HALT, halted=1, pc stays 31.
//  stall held 3 cycles mid-RUN -> pc, retired unchanged; release resumes at same pc.
//  Assert rst while HALT or RUN -> next cycle pc=0, IDLE, retired=0; start ignored w/o rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit core fetch path: opcodes, field positions, FSM states.
package cpu_pkg;

   localparam int unsigned PC_W_DEF = 5;

   localparam logic [3:0] OP_BEQ = 4'b1100;
   localparam logic [3:0] OP_BNE = 4'b1110;
   localparam logic [3:0] OP_J   = 4'b1111;

   localparam int unsigned OP_HI  = 15;
   localparam int unsigned OP_LO  = 12;
   localparam int unsigned OFF_HI = 3;
   localparam int unsigned OFF_LO = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HALT
   } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken branch (pc+1+sext offset) or pc+1.
module next_pc_calc
   import cpu_pkg::*;
#(
   parameter int unsigned PC_W = PC_W_DEF
) (
   input  logic [PC_W-1:0] pc,
   input  logic [15:0]     instruction,
   input  logic            regs_equal,
   output logic [PC_W-1:0] next_pc,
   output logic            self_jump
);

   logic [3:0]        op;
   logic signed [3:0] offset;
   logic [PC_W-1:0]   target;
   logic [PC_W-1:0]   seq_pc;
   logic [PC_W-1:0]   branch_pc;
   logic              take_branch;
   logic              unused_reg_fields;

   assign op         = instruction[OP_HI:OP_LO];
   assign offset     = instruction[OFF_HI:OFF_LO];
   assign target     = instruction[PC_W-1:0];
   assign seq_pc     = pc + PC_W'(1);
   // Sum is truncated to PC_W, giving the required modulo-2**PC_W wrap.
   assign branch_pc  = seq_pc + PC_W'($signed(offset));
   assign take_branch = ((op == OP_BEQ) && regs_equal) || ((op == OP_BNE) && !regs_equal);
   assign unused_reg_fields = ^instruction[11:4];

   always_comb begin
      next_pc   = seq_pc;
      self_jump = 1'b0;
      if (op == OP_J) begin
         next_pc   = target;
         self_jump = (target == pc);
      end else if (take_branch) begin
         next_pc = branch_pc;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and IDLE/RUN/HALT fetch sequencer with stall and saturating retire count.
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stall,
   input  logic [15:0]      instruction,
   input  logic             regs_equal,
   output logic [PC_W-1:0]  pc,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   fetch_state_t    state;
   logic [PC_W-1:0] next_pc;
   logic            self_jump;

   next_pc_calc #(
      .PC_W(PC_W)
   ) u_next_pc_calc (
      .pc          (pc),
      .instruction (instruction),
      .regs_equal  (regs_equal),
      .next_pc     (next_pc),
      .self_jump   (self_jump)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pc      <= RESET_PC;
         retired <= '0;
         running <= 1'b0;
         halted  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  if (retired != '1) retired <= retired + CNT_W'(1);
                  // A self-jump retires but parks the core with pc unchanged.
                  if (self_jump) begin
                     state   <= ST_HALT;
                     running <= 1'b0;
                     halted  <= 1'b1;
                  end else begin
                     pc <= next_pc;
                  end
               end
            end
            ST_HALT: ;
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed program walks then randomized ROM/control.
module tb_pc_fetch_unit;

   localparam int CW   = 5;
   localparam int RMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          stall_i = 1'b0;
   logic          regs_eq_i = 1'b0;
   logic [15:0]   instr = '0;
   logic [4:0]    pc;
   logic          running;
   logic          halted;
   logic [CW-1:0] retired;

   logic [15:0] rom [32];

   int m_pc = 0;
   int m_ret = 0;
   bit m_run = 0;
   bit m_halt = 0;
   bit chk_en = 0;

   int total = 0;
   int bad = 0;

   pc_fetch_unit #(
      .PC_W     (5),
      .RESET_PC (5'd0),
      .CNT_W    (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst_i),
      .start       (start_i),
      .stall       (stall_i),
      .instruction (instr),
      .regs_equal  (regs_eq_i),
      .pc          (pc),
      .running     (running),
      .halted      (halted),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   // Architectural model: applies the fetch rules to the word the bench presented this cycle.
   task automatic model_step();
      int op, off, tgt;
      if (rst_i) begin
         m_pc = 0; m_ret = 0; m_run = 0; m_halt = 0;
      end else if (!m_run && !m_halt) begin
         if (start_i) m_run = 1;
      end else if (m_run && !stall_i) begin
         if (m_ret < RMAX) m_ret++;
         op  = int'(instr[15:12]);
         off = int'(instr[3:0]);
         if (off > 7) off -= 16;
         tgt = int'(instr[4:0]);
         if (op == 15) begin
            if (tgt == m_pc) begin m_run = 0; m_halt = 1; end
            else m_pc = tgt;
         end else if ((op == 14 && !regs_eq_i) || (op == 12 && regs_eq_i)) begin
            m_pc = (m_pc + 1 + off + 32) % 32;
         end else begin
            m_pc = (m_pc + 1) % 32;
         end
      end
   endtask

   task automatic cyc(input bit r, input bit s, input bit st, input bit eq);
      rst_i = r; start_i = s; stall_i = st; regs_eq_i = eq;
      instr = rom[m_pc];
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc", int'(pc), m_pc);
         chk("running", int'(running), int'(m_run));
         chk("halted", int'(halted), int'(m_halt));
         chk("retired", int'(retired), m_ret);
         chk("run_halt_excl", int'(running & halted), 0);
      end
   end

   initial begin
      logic [15:0] w;
      for (int i = 0; i < 32; i++) rom[i] = 16'h0000;

      cyc(1, 0, 0, 0);
      chk_en = 1;
      chk("rst_pc", int'(pc), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_retired", int'(retired), 0);

      cyc(0, 0, 0, 0);
      chk("idle_pc", int'(pc), 0);
      cyc(0, 1, 0, 0);
      chk("start_running", int'(running), 1);
      chk("start_pc", int'(pc), 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0);
         chk("seq_pc", int'(pc), i + 1);
      end
      chk("seq_retired", int'(retired), 4);

      rom[4] = 16'hF007; rom[7] = 16'hE30D; rom[5] = 16'hF007;
      rom[8] = 16'hF01F; rom[31] = 16'h0000; rom[1] = 16'hC00D;
      cyc(0, 0, 0, 0);
      chk("jump7", int'(pc), 7);
      cyc(0, 0, 0, 0);
      chk("bne_taken", int'(pc), 5);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("bne_not_taken", int'(pc), 8);
      cyc(0, 0, 0, 0);
      chk("jump31", int'(pc), 31);
      cyc(0, 0, 0, 0);
      chk("wrap0", int'(pc), 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("beq_neg", int'(pc), 31);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
      chk("stall_pc", int'(pc), 31);
      chk("stall_retired", int'(retired), 12);
      cyc(0, 0, 0, 0);
      chk("resume_pc", int'(pc), 0);
      chk("resume_retired", int'(retired), 13);

      cyc(1, 0, 0, 0);
      chk("rst_run_pc", int'(pc), 0);
      chk("rst_run_state", int'(running), 0);
      chk("rst_run_retired", int'(retired), 0);

      rom[0] = 16'hF00B; rom[11] = 16'hF01F; rom[31] = 16'hF01F;
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      chk("jump11", int'(pc), 11);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("halt_flag", int'(halted), 1);
      chk("halt_pc", int'(pc), 31);
      chk("halt_retired", int'(retired), 3);
      cyc(0, 1, 0, 0);
      cyc(0, 1, 0, 0);
      chk("halt_start_ign", int'(halted), 1);
      cyc(1, 0, 0, 0);
      chk("rst_halt_pc", int'(pc), 0);
      chk("rst_halt_flag", int'(halted), 0);

      for (int i = 0; i < 32; i++) rom[i] = 16'h1234;
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0);
      chk("retired_sat", int'(retired), RMAX);

      for (int i = 0; i < 32; i++) begin
         w = 16'($urandom);
         case ($urandom_range(0, 9))
            5, 6:    w[15:12] = 4'hC;
            7:       w[15:12] = 4'hE;
            8, 9:    w[15:12] = 4'hF;
            default: if (w[15:12] >= 4'hC) w[15:12] = 4'h3;
         endcase
         rom[i] = w;
      end
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 4000; i++)
         cyc(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0, 1'($urandom));

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
